// File: rtl/regfile_port_arbiter.sv
// Shares one register-file read port and one write port between N_UNITS execution units.
// A granted unit gets a one-cycle start pulse and keeps the ports until its busy falls.
module regfile_port_arbiter #(
  parameter int N_UNITS       = 4,
  parameter int START_TIMEOUT = 3,
  parameter int RR_EN         = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_UNITS-1:0]      req,
  output logic [N_UNITS-1:0]      unit_en,
  input  logic [N_UNITS-1:0]      unit_busy,
  input  logic [N_UNITS-1:0]      unit_read_en,
  input  logic [4*N_UNITS-1:0]    unit_read_reg,
  input  logic [N_UNITS-1:0]      unit_write_en,
  input  logic [4*N_UNITS-1:0]    unit_write_reg,
  input  logic [32*N_UNITS-1:0]   unit_write_value,
  input  logic [N_UNITS-1:0]      unit_write_restore_from_SPSR,
  output logic                    rf_read_en,
  output logic [3:0]              rf_read_reg,
  output logic                    rf_write_en,
  output logic [3:0]              rf_write_reg,
  output logic [31:0]             rf_write_value,
  output logic                    rf_write_restore_from_SPSR,
  output logic [N_UNITS-1:0]      grant,
  output logic                    arb_busy,
  output logic                    protocol_err
);

  localparam int PTR_W = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
  localparam int TMO_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
  localparam logic [PTR_W:0]   N_W      = (PTR_W+1)'(N_UNITS);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(START_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_OWNED = 2'd2
  } state_t;

  state_t               r_state, w_state_next;
  logic [N_UNITS-1:0]   r_grant, w_grant_next;
  logic [N_UNITS-1:0]   r_unit_en, w_unit_en_next;
  logic                 r_arb_busy, w_arb_busy_next;
  logic                 r_err, w_err_next;
  logic [PTR_W-1:0]     r_rr_ptr, w_rr_ptr_next;
  logic [TMO_W-1:0]     r_tmo_cnt, w_tmo_cnt_next;

  logic [PTR_W:0]       w_rr_base;
  logic [PTR_W:0]       w_cand;
  logic [PTR_W-1:0]     w_win_idx;
  logic                 w_win_found;
  logic [PTR_W:0]       w_ptr_inc;
  logic [PTR_W-1:0]     w_ptr_after_win;
  logic [N_UNITS-1:0]   w_win_onehot;
  logic                 w_owner_busy;
  logic                 w_bad_write;

  // Search starts at rr_ptr in round-robin mode, at 0 in fixed-priority mode.
  assign w_rr_base = (RR_EN != 0) ? {1'b0, r_rr_ptr} : '0;

  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    w_cand      = '0;
    for (int k = 0; k < N_UNITS; k++) begin
      w_cand = w_rr_base + (PTR_W+1)'(k);
      if (w_cand >= N_W) begin
        w_cand = w_cand - N_W;
      end
      if (!w_win_found && req[w_cand[PTR_W-1:0]]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_cand[PTR_W-1:0];
      end
    end
  end

  assign w_ptr_inc       = {1'b0, w_win_idx} + (PTR_W+1)'(1);
  assign w_ptr_after_win = (w_ptr_inc == N_W) ? '0 : w_ptr_inc[PTR_W-1:0];
  assign w_win_onehot    = N_UNITS'(1) << w_win_idx;
  assign w_owner_busy    = |(unit_busy & r_grant);
  assign w_bad_write     = |(unit_write_en & ~r_grant);

  // AND-OR port mux: with no owner every term is masked, so all rf_* outputs read 0.
  always_comb begin
    rf_read_en                 = 1'b0;
    rf_read_reg                = '0;
    rf_write_en                = 1'b0;
    rf_write_reg               = '0;
    rf_write_value             = '0;
    rf_write_restore_from_SPSR = 1'b0;
    for (int k = 0; k < N_UNITS; k++) begin
      rf_read_en     = rf_read_en | (unit_read_en[k] & r_grant[k]);
      rf_read_reg    = rf_read_reg | (unit_read_reg[4*k +: 4] & {4{r_grant[k]}});
      rf_write_en    = rf_write_en | (unit_write_en[k] & r_grant[k]);
      rf_write_reg   = rf_write_reg | (unit_write_reg[4*k +: 4] & {4{r_grant[k]}});
      rf_write_value = rf_write_value | (unit_write_value[32*k +: 32] & {32{r_grant[k]}});
      rf_write_restore_from_SPSR = rf_write_restore_from_SPSR |
                                   (unit_write_restore_from_SPSR[k] & r_grant[k]);
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_grant_next    = r_grant;
    w_unit_en_next  = '0;
    w_arb_busy_next = r_arb_busy;
    w_err_next      = r_err | w_bad_write;
    w_rr_ptr_next   = r_rr_ptr;
    w_tmo_cnt_next  = r_tmo_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_win_found) begin
          w_grant_next    = w_win_onehot;
          w_unit_en_next  = w_win_onehot;
          w_arb_busy_next = 1'b1;
          w_tmo_cnt_next  = '0;
          w_state_next    = S_START;
          if (RR_EN != 0) begin
            w_rr_ptr_next = w_ptr_after_win;
          end
        end
      end
      S_START: begin
        if (w_owner_busy) begin
          w_state_next = S_OWNED;
        end else if (r_tmo_cnt == TMO_LAST) begin
          // Owner never acknowledged its start pulse: drop it and flag.
          w_err_next      = 1'b1;
          w_grant_next    = '0;
          w_arb_busy_next = 1'b0;
          w_state_next    = S_IDLE;
        end else begin
          w_tmo_cnt_next = r_tmo_cnt + TMO_W'(1);
        end
      end
      S_OWNED: begin
        if (!w_owner_busy) begin
          w_grant_next    = '0;
          w_arb_busy_next = 1'b0;
          w_state_next    = S_IDLE;
        end
      end
      default: begin
        w_grant_next    = '0;
        w_arb_busy_next = 1'b0;
        w_state_next    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_unit_en  <= '0;
      r_arb_busy <= 1'b0;
      r_err      <= 1'b0;
      r_rr_ptr   <= '0;
      r_tmo_cnt  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_grant    <= w_grant_next;
      r_unit_en  <= w_unit_en_next;
      r_arb_busy <= w_arb_busy_next;
      r_err      <= w_err_next;
      r_rr_ptr   <= w_rr_ptr_next;
      r_tmo_cnt  <= w_tmo_cnt_next;
    end
  end

  assign unit_en      = r_unit_en;
  assign grant        = r_grant;
  assign arb_busy     = r_arb_busy;
  assign protocol_err = r_err;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Bench for regfile_port_arbiter: a round-robin instance (dut0) and a fixed-priority instance (dut1)
// driven by a simple execution-unit model; grant order is checked against a scoreboard queue.
module tb_regfile_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  req_v  [2];
  logic [3:0]  busy_v [2];
  logic [3:0]  wen_v  [2];
  logic [3:0]  ren;
  logic [15:0] rreg;
  logic [15:0] wreg;
  logic [127:0] wval;
  logic [3:0]  spsr;

  logic [3:0]  en_o    [2];
  logic [3:0]  grant_o [2];
  logic        rre_o   [2];
  logic [3:0]  rrg_o   [2];
  logic        rwe_o   [2];
  logic [3:0]  rwg_o   [2];
  logic [31:0] rwv_o   [2];
  logic        rsp_o   [2];
  logic        abusy_o [2];
  logic        perr_o  [2];

  regfile_port_arbiter #(.N_UNITS(4), .START_TIMEOUT(3), .RR_EN(1)) dut0 (
    .clk(clk), .rst(rst), .req(req_v[0]), .unit_en(en_o[0]), .unit_busy(busy_v[0]),
    .unit_read_en(ren), .unit_read_reg(rreg), .unit_write_en(wen_v[0]),
    .unit_write_reg(wreg), .unit_write_value(wval), .unit_write_restore_from_SPSR(spsr),
    .rf_read_en(rre_o[0]), .rf_read_reg(rrg_o[0]), .rf_write_en(rwe_o[0]),
    .rf_write_reg(rwg_o[0]), .rf_write_value(rwv_o[0]),
    .rf_write_restore_from_SPSR(rsp_o[0]), .grant(grant_o[0]), .arb_busy(abusy_o[0]),
    .protocol_err(perr_o[0])
  );

  regfile_port_arbiter #(.N_UNITS(4), .START_TIMEOUT(3), .RR_EN(0)) dut1 (
    .clk(clk), .rst(rst), .req(req_v[1]), .unit_en(en_o[1]), .unit_busy(busy_v[1]),
    .unit_read_en(ren), .unit_read_reg(rreg), .unit_write_en(wen_v[1]),
    .unit_write_reg(wreg), .unit_write_value(wval), .unit_write_restore_from_SPSR(spsr),
    .rf_read_en(rre_o[1]), .rf_read_reg(rrg_o[1]), .rf_write_en(rwe_o[1]),
    .rf_write_reg(rwg_o[1]), .rf_write_value(rwv_o[1]),
    .rf_write_restore_from_SPSR(rsp_o[1]), .grant(grant_o[1]), .arb_busy(abusy_o[1]),
    .protocol_err(perr_o[1])
  );

  // Unit model: busy rises one cycle after unit_en and stays up busy_len cycles (0 = never).
  int busy_len [2][4];
  bit wr_mode  [2][4];
  bit pend     [2][4];
  int cnt      [2][4];

  int exp_q0[$];
  int exp_q1[$];
  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] prev_g0, prev_g1, oh0, oh1;
  int e0, e1;

  // Scoreboard side: every start pulse must match the next expected winner and follow an idle cycle.
  always @(negedge clk) begin
    if (en_o[0] != 4'b0000) begin
      n_cmp++;
      if (exp_q0.size() == 0) begin
        n_err++;
        $display("FAIL sb_dut0_unexpected: unit_en=%b, required no grant", en_o[0]);
      end else begin
        e0 = exp_q0.pop_front();
        oh0 = 4'b0001 << e0;
        $display("dut0 grant: unit_en=%b grant=%b expected unit %0d", en_o[0], grant_o[0], e0);
        if (en_o[0] !== oh0 || grant_o[0] !== oh0) begin
          n_err++;
          $display("FAIL sb_dut0_order: unit_en=%b grant=%b, required %b", en_o[0], grant_o[0], oh0);
        end
      end
      n_cmp++;
      if (prev_g0 !== 4'b0000) begin
        n_err++;
        $display("FAIL dead_cycle_dut0: previous grant=%b, required 0000", prev_g0);
      end
    end
    if (en_o[1] != 4'b0000) begin
      n_cmp++;
      if (exp_q1.size() == 0) begin
        n_err++;
        $display("FAIL sb_dut1_unexpected: unit_en=%b, required no grant", en_o[1]);
      end else begin
        e1 = exp_q1.pop_front();
        oh1 = 4'b0001 << e1;
        $display("dut1 grant: unit_en=%b grant=%b expected unit %0d", en_o[1], grant_o[1], e1);
        if (en_o[1] !== oh1 || grant_o[1] !== oh1) begin
          n_err++;
          $display("FAIL sb_dut1_order: unit_en=%b grant=%b, required %b", en_o[1], grant_o[1], oh1);
        end
      end
      n_cmp++;
      if (prev_g1 !== 4'b0000) begin
        n_err++;
        $display("FAIL dead_cycle_dut1: previous grant=%b, required 0000", prev_g1);
      end
    end
    prev_g0 = grant_o[0];
    prev_g1 = grant_o[1];
  end

  task automatic tick;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        if (cnt[d][i] > 0) begin
          cnt[d][i]--;
          if (cnt[d][i] == 0) begin
            busy_v[d][i] = 1'b0;
            wen_v[d][i]  = 1'b0;
          end
        end
        if (pend[d][i]) begin
          pend[d][i] = 1'b0;
          if (busy_len[d][i] > 0) begin
            busy_v[d][i] = 1'b1;
            cnt[d][i]    = busy_len[d][i];
            if (wr_mode[d][i]) wen_v[d][i] = 1'b1;
          end
        end
        if (en_o[d][i]) begin
          req_v[d][i] = 1'b0;
          pend[d][i]  = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic clear_units;
    for (int d = 0; d < 2; d++) begin
      req_v[d]  = 4'b0000;
      busy_v[d] = 4'b0000;
      wen_v[d]  = 4'b0000;
      for (int i = 0; i < 4; i++) begin
        busy_len[d][i] = 0;
        wr_mode[d][i]  = 1'b0;
        pend[d][i]     = 1'b0;
        cnt[d][i]      = 0;
      end
    end
    ren  = 4'hF;
    rreg = 16'h7531;
    wreg = 16'h0000;
    wval = '0;
    spsr = 4'b0001;
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    clear_units();
    exp_q0.delete();
    exp_q1.delete();
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic drain(input int budget);
    int t;
    t = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0 || grant_o[0] != 0 || grant_o[1] != 0 ||
            req_v[0] != 0 || req_v[1] != 0) && t < budget) begin
      tick();
      t++;
    end
    n_cmp++;
    if (t >= budget) begin
      n_err++;
      $display("FAIL drain_timeout: %0d cycles, pending q0=%0d q1=%0d", t, exp_q0.size(), exp_q1.size());
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    clear_units();
    repeat (2) tick();
    n_cmp++;
    if (grant_o[0] !== 4'b0000 || en_o[0] !== 4'b0000 || abusy_o[0] !== 1'b0 || perr_o[0] !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: grant=%b en=%b busy=%b err=%b, required 0000 0000 0 0",
               grant_o[0], en_o[0], abusy_o[0], perr_o[0]);
    end
    n_cmp++;
    if (rre_o[0] !== 1'b0 || rwe_o[0] !== 1'b0 || rwv_o[0] !== 32'h0 || rsp_o[0] !== 1'b0) begin
      n_err++;
      $display("FAIL reset_rf_zero: rd_en=%b wr_en=%b wval=%h spsr=%b, required all 0",
               rre_o[0], rwe_o[0], rwv_o[0], rsp_o[0]);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_owner;
    int en_cyc, g_cyc, w_cyc;
    en_cyc = 0; g_cyc = 0; w_cyc = 0;
    busy_len[0][0] = 4;
    wr_mode[0][0]  = 1'b1;
    wreg[3:0]      = 4'd15;
    wval[31:0]     = 32'h0000_1008;
    exp_q0.push_back(0);
    req_v[0][0] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (en_o[0][0]) en_cyc++;
      if (grant_o[0] == 4'b0001) begin
        g_cyc++;
        n_cmp++;
        if (rre_o[0] !== 1'b1 || rrg_o[0] !== 4'h1 || rsp_o[0] !== 1'b1 || abusy_o[0] !== 1'b1) begin
          n_err++;
          $display("FAIL owner_read_mux: rd_en=%b rd_reg=%h spsr=%b busy=%b, required 1 1 1 1",
                   rre_o[0], rrg_o[0], rsp_o[0], abusy_o[0]);
        end
        if (wen_v[0][0]) begin
          w_cyc++;
          n_cmp++;
          if (rwe_o[0] !== 1'b1 || rwg_o[0] !== 4'd15 || rwv_o[0] !== 32'h0000_1008) begin
            n_err++;
            $display("FAIL owner_write_mux: en=%b reg=%0d val=%h, required 1 15 00001008",
                     rwe_o[0], rwg_o[0], rwv_o[0]);
          end
        end
      end else begin
        n_cmp++;
        if (rwe_o[0] !== 1'b0 || rre_o[0] !== 1'b0 || rsp_o[0] !== 1'b0 || abusy_o[0] !== 1'b0) begin
          n_err++;
          $display("FAIL idle_rf_zero: grant=%b wr_en=%b rd_en=%b spsr=%b busy=%b, required zeros",
                   grant_o[0], rwe_o[0], rre_o[0], rsp_o[0], abusy_o[0]);
        end
      end
    end
    n_cmp++;
    if (en_cyc != 1 || g_cyc != 6 || w_cyc != 4) begin
      n_err++;
      $display("FAIL single_timing: en_cycles=%0d grant_cycles=%0d write_cycles=%0d, required 1 6 4",
               en_cyc, g_cyc, w_cyc);
    end
    n_cmp++;
    if (perr_o[0] !== 1'b0) begin
      n_err++;
      $display("FAIL single_no_err: protocol_err=%b, required 0", perr_o[0]);
    end
  endtask

  task automatic test_round_robin;
    apply_reset();
    busy_len[0][1] = 2;
    busy_len[0][3] = 2;
    exp_q0.push_back(1);
    exp_q0.push_back(3);
    req_v[0] = 4'b1010;
    drain(60);
    // A lone unit1 grant leaves the pointer at 2, so the next 1010 serves unit3 first.
    exp_q0.push_back(1);
    req_v[0] = 4'b0010;
    drain(30);
    exp_q0.push_back(3);
    exp_q0.push_back(1);
    req_v[0] = 4'b1010;
    drain(60);
    n_cmp++;
    if (perr_o[0] !== 1'b0) begin
      n_err++;
      $display("FAIL rr_no_err: protocol_err=%b, required 0", perr_o[0]);
    end
  endtask

  task automatic test_blocked_write;
    int t;
    busy_len[0][0] = 4;
    wr_mode[0][0]  = 1'b1;
    wreg           = 16'h050E;
    wval[31:0]     = 32'h0000_0104;
    wval[95:64]    = 32'hDEAD_BEEF;
    exp_q0.push_back(0);
    req_v[0] = 4'b0001;
    t = 0;
    while (!(grant_o[0] == 4'b0001 && wen_v[0][0]) && t < 20) begin
      tick();
      t++;
    end
    n_cmp++;
    if (t >= 20) begin
      n_err++;
      $display("FAIL blocked_setup_timeout: grant=%b, required 0001 with write", grant_o[0]);
    end
    wen_v[0][2] = 1'b1;
    #1;
    n_cmp++;
    if (rwe_o[0] !== 1'b1 || rwg_o[0] !== 4'd14 || rwv_o[0] !== 32'h0000_0104 || perr_o[0] !== 1'b0) begin
      n_err++;
      $display("FAIL blocked_mux: en=%b reg=%0d val=%h err=%b, required 1 14 00000104 0",
               rwe_o[0], rwg_o[0], rwv_o[0], perr_o[0]);
    end
    tick();
    wen_v[0][2] = 1'b0;
    n_cmp++;
    if (perr_o[0] !== 1'b1) begin
      n_err++;
      $display("FAIL blocked_err_set: protocol_err=%b, required 1", perr_o[0]);
    end
    drain(30);
    n_cmp++;
    if (perr_o[0] !== 1'b1) begin
      n_err++;
      $display("FAIL blocked_err_sticky: protocol_err=%b, required 1", perr_o[0]);
    end
  endtask

  task automatic test_timeout;
    int t;
    apply_reset();
    busy_len[0][1] = 0;
    exp_q0.push_back(1);
    req_v[0] = 4'b0010;
    t = 0;
    while (!en_o[0][1] && t < 10) begin
      tick();
      t++;
    end
    n_cmp++;
    if (t >= 10) begin
      n_err++;
      $display("FAIL timeout_no_pulse: unit_en=%b, required 0010", en_o[0]);
    end
    for (int c = 1; c <= 2; c++) begin
      tick();
      n_cmp++;
      if (grant_o[0] !== 4'b0010 || perr_o[0] !== 1'b0) begin
        n_err++;
        $display("FAIL timeout_hold_c%0d: grant=%b err=%b, required 0010 0", c, grant_o[0], perr_o[0]);
      end
    end
    tick();
    n_cmp++;
    if (grant_o[0] !== 4'b0000 || perr_o[0] !== 1'b1 || abusy_o[0] !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_release: grant=%b err=%b busy=%b, required 0000 1 0",
               grant_o[0], perr_o[0], abusy_o[0]);
    end
    tick();
    n_cmp++;
    if (perr_o[0] !== 1'b1 || grant_o[0] !== 4'b0000) begin
      n_err++;
      $display("FAIL timeout_sticky: err=%b grant=%b, required 1 0000", perr_o[0], grant_o[0]);
    end
  endtask

  task automatic test_reset_mid_owned;
    int t;
    apply_reset();
    busy_len[0][2] = 6;
    wr_mode[0][2]  = 1'b1;
    exp_q0.push_back(2);
    req_v[0] = 4'b0100;
    t = 0;
    while (!(grant_o[0] == 4'b0100 && busy_v[0][2]) && t < 20) begin
      tick();
      t++;
    end
    tick();
    wen_v[0][0] = 1'b1;
    tick();
    wen_v[0][0] = 1'b0;
    n_cmp++;
    if (perr_o[0] !== 1'b1 || grant_o[0] !== 4'b0100) begin
      n_err++;
      $display("FAIL mid_setup: err=%b grant=%b, required 1 0100", perr_o[0], grant_o[0]);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if (grant_o[0] !== 4'b0000 || rwe_o[0] !== 1'b0 || abusy_o[0] !== 1'b0 || perr_o[0] !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: grant=%b wr_en=%b busy=%b err=%b, required 0000 0 0 0",
               grant_o[0], rwe_o[0], abusy_o[0], perr_o[0]);
    end
    clear_units();
    exp_q0.delete();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_fixed_priority;
    int regrants, t;
    apply_reset();
    for (int i = 0; i < 4; i++) busy_len[1][i] = 1;
    exp_q1.push_back(0);
    exp_q1.push_back(0);
    exp_q1.push_back(0);
    exp_q1.push_back(1);
    exp_q1.push_back(2);
    exp_q1.push_back(3);
    req_v[1] = 4'b1111;
    regrants = 0;
    t = 0;
    while ((exp_q1.size() != 0 || grant_o[1] != 0) && t < 100) begin
      tick();
      t++;
      if (en_o[1][0] && regrants < 2) begin
        req_v[1][0] = 1'b1;
        regrants++;
      end
    end
    n_cmp++;
    if (t >= 100) begin
      n_err++;
      $display("FAIL fixed_timeout: %0d grants outstanding", exp_q1.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    prev_g0 = 4'b0000;
    prev_g1 = 4'b0000;
    test_reset();
    test_single_owner();
    test_round_robin();
    test_blocked_write();
    test_timeout();
    test_reset_mid_owned();
    test_fixed_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
